tsqr_tile_loader: RTL and testbench

// - Input scheduler for the single-core TSQR (streaming width 4): accepts 128-bit u/p row beats (4x FP32) from a

---
 rtl/tsqr_pkg.sv | 15 +
 rtl/tsqr_bank_flag.sv | 24 ++
 rtl/tsqr_tile_loader.sv | 150 +++++++++++++++
 tb/tb_tsqr_tile_loader.sv | 513 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tsqr_pkg.sv
// Shared TSQR constants and the tile-loader state encoding.
package tsqr_pkg;

  localparam int FP32_W      = 32;
  localparam int LANES       = 4;
  localparam int TSQR_DATA_W = LANES * FP32_W;
  localparam int TSQR_CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } load_state_e;

endpackage

// File: rtl/tsqr_bank_flag.sv
// Per-bank "tile full" flag: set by the loader, cleared by the core's release pulse.
module tsqr_bank_flag (
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic rel,
  output logic fi
);

  logic fi_q, fi_d;

  // A set arriving with a release means the next tile is already in the bank, so set wins.
  always_comb begin
    fi_d = set | (fi_q & ~rel);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fi_q <= 1'b0;
    else     fi_q <= fi_d;
  end

  assign fi = fi_q;

endmodule

// File: rtl/tsqr_tile_loader.sv
// Streams u/p row beats from a valid/ready source into the TSQR core's ping-pong tile banks.
module tsqr_tile_loader
  import tsqr_pkg::*;
#(
  parameter int DATA_W = TSQR_DATA_W,
  parameter int BEATS  = 2,
  parameter int ADDR_W = 6,
  parameter int CNT_W  = TSQR_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  tile_no,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_ug,
  input  logic [DATA_W-1:0] s_pg,
  output logic              mem0_we,
  output logic              mem1_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_ug_din,
  output logic [DATA_W-1:0] mem_pg_din,
  output logic              mem0_fi,
  output logic              mem1_fi,
  input  logic              mem0_rel,
  input  logic              mem1_rel,
  output logic [CNT_W-1:0]  tiles_loaded,
  output logic              load_fi,
  output logic              busy
);

  load_state_e       state_q, state_d;
  logic              bank_q, bank_d;
  logic [ADDR_W-1:0] beat_q, beat_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  tiles_q, tiles_d;
  logic [CNT_W-1:0]  tile_no_q, tile_no_d;
  logic              we0_q, we0_d, we1_q, we1_d;
  logic              last_q, last_d;
  logic [DATA_W-1:0] ug_q, ug_d, pg_q, pg_d;
  logic [CNT_W-1:0]  tiles_next;
  logic              fi0, fi1, hs;

  // Ready depends only on registered state so the source never sees a loop through s_valid.
  assign s_ready    = (state_q == FILL) && !(bank_q ? fi1 : fi0);
  assign hs         = s_valid && s_ready;
  assign tiles_next = tiles_q + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    bank_d    = bank_q;
    beat_d    = beat_q;
    addr_d    = addr_q;
    tiles_d   = tiles_q;
    tile_no_d = tile_no_q;
    ug_d      = ug_q;
    pg_d      = pg_q;
    we0_d     = 1'b0;
    we1_d     = 1'b0;
    last_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          tile_no_d = tile_no;
          tiles_d   = '0;
          bank_d    = 1'b0;
          beat_d    = '0;
          state_d   = (tile_no == '0) ? DONE : FILL;
        end
      end
      FILL: begin
        if (hs) begin
          we0_d  = ~bank_q;
          we1_d  = bank_q;
          addr_d = beat_q;
          ug_d   = s_ug;
          pg_d   = s_pg;
          if (beat_q == ADDR_W'(BEATS - 1)) begin
            last_d  = 1'b1;
            beat_d  = '0;
            bank_d  = ~bank_q;
            tiles_d = tiles_next;
            if (tiles_next == tile_no_q) state_d = DONE;
          end else begin
            beat_d = beat_q + ADDR_W'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bank_q    <= 1'b0;
      beat_q    <= '0;
      addr_q    <= '0;
      tiles_q   <= '0;
      tile_no_q <= '0;
      ug_q      <= '0;
      pg_q      <= '0;
      we0_q     <= 1'b0;
      we1_q     <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bank_q    <= bank_d;
      beat_q    <= beat_d;
      addr_q    <= addr_d;
      tiles_q   <= tiles_d;
      tile_no_q <= tile_no_d;
      ug_q      <= ug_d;
      pg_q      <= pg_d;
      we0_q     <= we0_d;
      we1_q     <= we1_d;
      last_q    <= last_d;
    end
  end

  // A bank becomes full on the edge that retires its final write strobe.
  tsqr_bank_flag u_flag0 (
    .clk (clk),
    .rst (rst),
    .set (we0_q & last_q),
    .rel (mem0_rel),
    .fi  (fi0)
  );

  tsqr_bank_flag u_flag1 (
    .clk (clk),
    .rst (rst),
    .set (we1_q & last_q),
    .rel (mem1_rel),
    .fi  (fi1)
  );

  assign mem0_we      = we0_q;
  assign mem1_we      = we1_q;
  assign mem_addr     = addr_q;
  assign mem_ug_din   = ug_q;
  assign mem_pg_din   = pg_q;
  assign mem0_fi      = fi0;
  assign mem1_fi      = fi1;
  assign tiles_loaded = tiles_q;
  assign load_fi      = (state_q == DONE);
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_tsqr_tile_loader.sv
// Self-checking bench for tsqr_tile_loader: randomized beats scored against a tile/bank placement model.
module tb_tsqr_tile_loader;

  localparam int DATA_W = 128;
  localparam int BEATS  = 2;
  localparam int ADDR_W = 6;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [CNT_W-1:0]  tile_no = '0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [DATA_W-1:0] s_ug = '0;
  logic [DATA_W-1:0] s_pg = '0;
  logic              mem0_we, mem1_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_ug_din, mem_pg_din;
  logic              mem0_fi, mem1_fi;
  logic              mem0_rel = 1'b0;
  logic              mem1_rel = 1'b0;
  logic [CNT_W-1:0]  tiles_loaded;
  logic              load_fi, busy;

  tsqr_tile_loader #(
    .DATA_W (DATA_W),
    .BEATS  (BEATS),
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .tile_no      (tile_no),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_ug         (s_ug),
    .s_pg         (s_pg),
    .mem0_we      (mem0_we),
    .mem1_we      (mem1_we),
    .mem_addr     (mem_addr),
    .mem_ug_din   (mem_ug_din),
    .mem_pg_din   (mem_pg_din),
    .mem0_fi      (mem0_fi),
    .mem1_fi      (mem1_fi),
    .mem0_rel     (mem0_rel),
    .mem1_rel     (mem1_rel),
    .tiles_loaded (tiles_loaded),
    .load_fi      (load_fi),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                cyc;
    logic [DATA_W-1:0] ug;
    logic [DATA_W-1:0] pg;
  } acc_t;

  typedef struct {
    int                cyc;
    logic              bank;
    logic              dual;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] ug;
    logic [DATA_W-1:0] pg;
  } wr_t;

  acc_t              acc_q[$];
  wr_t               wr_q[$];
  int                fi0_rise_q[$];
  int                rel0_q[$];
  logic [DATA_W-1:0] ug_pool[16];
  logic [DATA_W-1:0] pg_pool[16];
  wr_t               mon_w;
  wr_t               exp_w;
  int                cyc = 0;
  int                lf_cnt = 0;
  logic              fi0_prev = 1'b0;
  bit                rel_en = 1'b0;
  int                rel0_cnt = -1;
  int                rel1_cnt = -1;
  int                n_cmp = 0;
  int                n_err = 0;

  always @(posedge clk) cyc++;

  // Passive monitor: logs every write strobe, fi0 rising edges and load_fi pulses.
  always @(negedge clk) begin
    if (mem0_we || mem1_we) begin
      mon_w.cyc  = cyc;
      mon_w.bank = mem1_we;
      mon_w.dual = mem0_we && mem1_we;
      mon_w.addr = mem_addr;
      mon_w.ug   = mem_ug_din;
      mon_w.pg   = mem_pg_din;
      wr_q.push_back(mon_w);
    end
    if (load_fi) lf_cnt++;
    if (mem0_fi && !fi0_prev) fi0_rise_q.push_back(cyc);
    fi0_prev = mem0_fi;
  end

  // Core stand-in: pulses the release two cycles after it sees a bank go full.
  always @(negedge clk) begin
    mem0_rel = 1'b0;
    mem1_rel = 1'b0;
    if (!rel_en) begin
      rel0_cnt = -1;
      rel1_cnt = -1;
    end else begin
      if (rel0_cnt > 0) begin
        rel0_cnt--;
        if (rel0_cnt == 0) begin
          mem0_rel = 1'b1;
          rel0_cnt = -1;
          rel0_q.push_back(cyc + 1);
        end
      end else if (mem0_fi) rel0_cnt = 2;
      if (rel1_cnt > 0) begin
        rel1_cnt--;
        if (rel1_cnt == 0) begin
          mem1_rel = 1'b1;
          rel1_cnt = -1;
        end
      end else if (mem1_fi) rel1_cnt = 2;
    end
  end

  // Reference placement: the k-th accepted beat of a run lands in bank (k/BEATS)%2 at
  // address k%BEATS, presented in the cycle right after its handshake edge.
  function automatic wr_t model_write(int k);
    wr_t w;
    w.cyc  = acc_q[k].cyc;
    w.bank = ((k / BEATS) % 2) == 1;
    w.dual = 1'b0;
    w.addr = ADDR_W'(k % BEATS);
    w.ug   = acc_q[k].ug;
    w.pg   = acc_q[k].pg;
    return w;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    acc_q.delete();
    wr_q.delete();
    fi0_rise_q.delete();
    rel0_q.delete();
    lf_cnt = 0;
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    start   = 1'b0;
    rst     = 1'b1;
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(1);
    clear_logs();
  endtask

  task automatic fill_pool();
    for (int i = 0; i < 16; i++) begin
      ug_pool[i] = {$urandom, $urandom, $urandom, $urandom};
      pg_pool[i] = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  task automatic pulse_start(input logic [CNT_W-1:0] n);
    start   = 1'b1;
    tile_no = n;
    wait_cycles(1);
    start = 1'b0;
  endtask

  // Source model: offers beats from the pool; mode 0 full rate, 1 alternating, 2 random valid.
  task automatic drive_beats(input int n, input int mode, input int max_cyc, output int acc_n);
    int   idx = 0;
    int   c = 0;
    acc_t a;
    while (idx < n && c < max_cyc) begin
      case (mode)
        0:       s_valid = 1'b1;
        1:       s_valid = (c % 2) == 0;
        default: s_valid = $urandom_range(0, 1) == 1;
      endcase
      s_ug = ug_pool[idx];
      s_pg = pg_pool[idx];
      @(negedge clk);
      if (s_valid && s_ready) begin
        a.cyc = cyc + 1;
        a.ug  = s_ug;
        a.pg  = s_pg;
        acc_q.push_back(a);
        idx++;
      end
      @(posedge clk);
      #1;
      c++;
    end
    s_valid = 1'b0;
    acc_n   = idx;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_cycles(2);
    n_cmp++;
    if ({s_ready, mem0_we, mem1_we, mem0_fi, mem1_fi, load_fi, busy} !== 7'b0) begin
      n_err++;
      $display("[TB] FAIL reset_ctrl: got %b, want 0000000",
               {s_ready, mem0_we, mem1_we, mem0_fi, mem1_fi, load_fi, busy});
    end
    n_cmp++;
    if (mem_addr !== '0 || tiles_loaded !== '0) begin
      n_err++;
      $display("[TB] FAIL reset_cnt: got addr=%0d tiles=%0d, want 0/0", mem_addr, tiles_loaded);
    end
    n_cmp++;
    if (mem_ug_din !== '0 || mem_pg_din !== '0) begin
      n_err++;
      $display("[TB] FAIL reset_data: got ug=%h pg=%h, want 0", mem_ug_din, mem_pg_din);
    end
    rst = 1'b0;
    wait_cycles(1);
    clear_logs();
  endtask

  task automatic test_full_rate();
    int got;
    $display("[TB] full-rate, tile_no=3, banks released");
    do_reset();
    fill_pool();
    rel_en = 1'b1;
    pulse_start(8'd3);
    drive_beats(6, 0, 100, got);
    wait_cycles(10);
    n_cmp++;
    if (got !== 6) begin
      n_err++;
      $display("[TB] FAIL full_accepted: got %0d, want 6", got);
    end
    n_cmp++;
    if (wr_q.size() !== acc_q.size()) begin
      n_err++;
      $display("[TB] FAIL full_wr_count: got %0d, want %0d", wr_q.size(), acc_q.size());
    end
    for (int k = 0; k < acc_q.size() && k < wr_q.size(); k++) begin
      exp_w = model_write(k);
      n_cmp++;
      if (wr_q[k].cyc !== exp_w.cyc || wr_q[k].bank !== exp_w.bank || wr_q[k].dual !== 1'b0 ||
          wr_q[k].addr !== exp_w.addr || wr_q[k].ug !== exp_w.ug || wr_q[k].pg !== exp_w.pg) begin
        n_err++;
        $display("[TB] FAIL full_write%0d: got cyc=%0d bank=%0d dual=%0d addr=%0d, want cyc=%0d bank=%0d addr=%0d (data eq=%0d)",
                 k, wr_q[k].cyc, wr_q[k].bank, wr_q[k].dual, wr_q[k].addr, exp_w.cyc, exp_w.bank,
                 exp_w.addr, (wr_q[k].ug === exp_w.ug) && (wr_q[k].pg === exp_w.pg));
      end
    end
    n_cmp++;
    if (fi0_rise_q.size() < 1 || acc_q.size() < 2 || fi0_rise_q[0] !== acc_q[1].cyc + 1) begin
      n_err++;
      $display("[TB] FAIL full_fi0_timing: got rise=%0d, want %0d",
               fi0_rise_q.size() > 0 ? fi0_rise_q[0] : -1, acc_q.size() > 1 ? acc_q[1].cyc + 1 : -1);
    end
    n_cmp++;
    if (rel0_q.size() < 1 || acc_q.size() < 5 || acc_q[4].cyc !== rel0_q[0] + 1) begin
      n_err++;
      $display("[TB] FAIL full_stall_5th: got accept=%0d, want %0d",
               acc_q.size() > 4 ? acc_q[4].cyc : -1, rel0_q.size() > 0 ? rel0_q[0] + 1 : -1);
    end
    n_cmp++;
    if (tiles_loaded !== 8'd3 || lf_cnt !== 1 || busy !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL full_done: got tiles=%0d load_fi=%0d busy=%0d, want 3/1/0", tiles_loaded, lf_cnt, busy);
    end
    n_cmp++;
    if (mem0_fi !== 1'b0 || mem1_fi !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL full_released: got fi0=%0d fi1=%0d, want 0/0", mem0_fi, mem1_fi);
    end
    rel_en = 1'b0;
  endtask

  task automatic test_data_integrity();
    int got;
    logic [DATA_W-1:0] ug_ref;
    logic [DATA_W-1:0] pg_ref;
    $display("[TB] data integrity, fixed FP32 beat");
    do_reset();
    fill_pool();
    ug_ref     = 128'h41100000_40000000_3F800000_40000000;
    pg_ref     = 128'hC0400000_C0000000_C0E00000_C0000000;
    ug_pool[0] = ug_ref;
    pg_pool[0] = pg_ref;
    pulse_start(8'd1);
    drive_beats(2, 0, 20, got);
    wait_cycles(3);
    n_cmp++;
    if (wr_q.size() !== 2) begin
      n_err++;
      $display("[TB] FAIL data_wr_count: got %0d, want 2", wr_q.size());
    end
    n_cmp++;
    if (wr_q.size() < 1 || acc_q.size() < 1 || wr_q[0].ug !== ug_ref || wr_q[0].pg !== pg_ref ||
        wr_q[0].bank !== 1'b0 || wr_q[0].addr !== '0 || wr_q[0].cyc !== acc_q[0].cyc) begin
      n_err++;
      $display("[TB] FAIL data_beat0: got ug=%h pg=%h, want ug=%h pg=%h at bank0 addr0",
               wr_q.size() > 0 ? wr_q[0].ug : '0, wr_q.size() > 0 ? wr_q[0].pg : '0, ug_ref, pg_ref);
    end
    n_cmp++;
    if (wr_q.size() < 2 || wr_q[1].ug !== ug_pool[1] || wr_q[1].pg !== pg_pool[1] || wr_q[1].addr !== 6'd1) begin
      n_err++;
      $display("[TB] FAIL data_beat1: got addr=%0d ug=%h, want addr=1 ug=%h",
               wr_q.size() > 1 ? wr_q[1].addr : '0, wr_q.size() > 1 ? wr_q[1].ug : '0, ug_pool[1]);
    end
  endtask

  task automatic test_gappy();
    int got;
    $display("[TB] gappy source, tile_no=3");
    do_reset();
    fill_pool();
    rel_en = 1'b1;
    pulse_start(8'd3);
    drive_beats(6, 1, 200, got);
    wait_cycles(10);
    n_cmp++;
    if (got !== 6 || wr_q.size() !== 6) begin
      n_err++;
      $display("[TB] FAIL gap_counts: got accepted=%0d writes=%0d, want 6/6", got, wr_q.size());
    end
    for (int k = 0; k < acc_q.size() && k < wr_q.size(); k++) begin
      exp_w = model_write(k);
      n_cmp++;
      if (wr_q[k].cyc !== exp_w.cyc || wr_q[k].bank !== exp_w.bank || wr_q[k].dual !== 1'b0 ||
          wr_q[k].addr !== exp_w.addr || wr_q[k].ug !== exp_w.ug || wr_q[k].pg !== exp_w.pg) begin
        n_err++;
        $display("[TB] FAIL gap_write%0d: got cyc=%0d bank=%0d addr=%0d, want cyc=%0d bank=%0d addr=%0d",
                 k, wr_q[k].cyc, wr_q[k].bank, wr_q[k].addr, exp_w.cyc, exp_w.bank, exp_w.addr);
      end
    end
    n_cmp++;
    if (tiles_loaded !== 8'd3 || lf_cnt !== 1) begin
      n_err++;
      $display("[TB] FAIL gap_done: got tiles=%0d load_fi=%0d, want 3/1", tiles_loaded, lf_cnt);
    end
    rel_en = 1'b0;
  endtask

  task automatic test_no_release();
    int got;
    $display("[TB] no release, tile_no=4");
    do_reset();
    fill_pool();
    rel_en = 1'b0;
    pulse_start(8'd4);
    drive_beats(8, 0, 30, got);
    n_cmp++;
    if (got !== 4 || wr_q.size() !== 4) begin
      n_err++;
      $display("[TB] FAIL norel_counts: got accepted=%0d writes=%0d, want 4/4", got, wr_q.size());
    end
    for (int k = 0; k < acc_q.size() && k < wr_q.size(); k++) begin
      exp_w = model_write(k);
      n_cmp++;
      if (wr_q[k].cyc !== exp_w.cyc || wr_q[k].bank !== exp_w.bank || wr_q[k].addr !== exp_w.addr ||
          wr_q[k].ug !== exp_w.ug || wr_q[k].pg !== exp_w.pg) begin
        n_err++;
        $display("[TB] FAIL norel_write%0d: got bank=%0d addr=%0d, want bank=%0d addr=%0d",
                 k, wr_q[k].bank, wr_q[k].addr, exp_w.bank, exp_w.addr);
      end
    end
    n_cmp++;
    if (s_ready !== 1'b0 || mem0_fi !== 1'b1 || mem1_fi !== 1'b1 || busy !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL norel_stall: got ready=%0d fi0=%0d fi1=%0d busy=%0d, want 0/1/1/1",
               s_ready, mem0_fi, mem1_fi, busy);
    end
    n_cmp++;
    if (tiles_loaded !== 8'd2 || lf_cnt !== 0) begin
      n_err++;
      $display("[TB] FAIL norel_progress: got tiles=%0d load_fi=%0d, want 2/0", tiles_loaded, lf_cnt);
    end
  endtask

  task automatic test_zero_and_busy_start();
    int got;
    $display("[TB] tile_no=0, then start while busy");
    do_reset();
    fill_pool();
    pulse_start(8'd0);
    @(negedge clk);
    n_cmp++;
    if (load_fi !== 1'b1 || busy !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL zero_pulse: got load_fi=%0d busy=%0d, want 1/1", load_fi, busy);
    end
    @(negedge clk);
    n_cmp++;
    if (load_fi !== 1'b0 || busy !== 1'b0 || tiles_loaded !== '0 || wr_q.size() !== 0) begin
      n_err++;
      $display("[TB] FAIL zero_after: got load_fi=%0d busy=%0d tiles=%0d writes=%0d, want 0/0/0/0",
               load_fi, busy, tiles_loaded, wr_q.size());
    end
    @(posedge clk);
    #1;
    clear_logs();
    rel_en = 1'b1;
    pulse_start(8'd2);
    tile_no = 8'd7;
    fork
      drive_beats(8, 2, 60, got);
      begin
        wait_cycles(2);
        pulse_start(8'd5);
      end
    join
    wait_cycles(6);
    n_cmp++;
    if (got !== 4 || tiles_loaded !== 8'd2 || lf_cnt !== 1 || busy !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL busy_start: got accepted=%0d tiles=%0d load_fi=%0d busy=%0d, want 4/2/1/0",
               got, tiles_loaded, lf_cnt, busy);
    end
    for (int k = 0; k < acc_q.size() && k < wr_q.size(); k++) begin
      exp_w = model_write(k);
      n_cmp++;
      if (wr_q[k].cyc !== exp_w.cyc || wr_q[k].bank !== exp_w.bank || wr_q[k].addr !== exp_w.addr ||
          wr_q[k].ug !== exp_w.ug || wr_q[k].pg !== exp_w.pg) begin
        n_err++;
        $display("[TB] FAIL busy_write%0d: got cyc=%0d bank=%0d addr=%0d, want cyc=%0d bank=%0d addr=%0d",
                 k, wr_q[k].cyc, wr_q[k].bank, wr_q[k].addr, exp_w.cyc, exp_w.bank, exp_w.addr);
      end
    end
    rel_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    int got;
    $display("[TB] reset mid-tile, then reload");
    do_reset();
    fill_pool();
    pulse_start(8'd2);
    drive_beats(1, 0, 10, got);
    n_cmp++;
    if (got !== 1 || mem0_we !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL mid_pre: got accepted=%0d we0=%0d, want 1/1", got, mem0_we);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({s_ready, mem0_we, mem1_we, mem0_fi, mem1_fi, load_fi, busy} !== 7'b0 ||
        mem_addr !== '0 || tiles_loaded !== '0 || mem_ug_din !== '0 || mem_pg_din !== '0) begin
      n_err++;
      $display("[TB] FAIL mid_reset: got ctrl=%b addr=%0d tiles=%0d, want all 0",
               {s_ready, mem0_we, mem1_we, mem0_fi, mem1_fi, load_fi, busy}, mem_addr, tiles_loaded);
    end
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(1);
    clear_logs();
    fill_pool();
    pulse_start(8'd1);
    drive_beats(2, 0, 20, got);
    wait_cycles(3);
    n_cmp++;
    if (got !== 2 || wr_q.size() !== 2 || tiles_loaded !== 8'd1 || lf_cnt !== 1) begin
      n_err++;
      $display("[TB] FAIL mid_reload: got accepted=%0d writes=%0d tiles=%0d load_fi=%0d, want 2/2/1/1",
               got, wr_q.size(), tiles_loaded, lf_cnt);
    end
    for (int k = 0; k < acc_q.size() && k < wr_q.size(); k++) begin
      exp_w = model_write(k);
      n_cmp++;
      if (wr_q[k].cyc !== exp_w.cyc || wr_q[k].bank !== exp_w.bank || wr_q[k].addr !== exp_w.addr ||
          wr_q[k].ug !== exp_w.ug || wr_q[k].pg !== exp_w.pg) begin
        n_err++;
        $display("[TB] FAIL mid_write%0d: got bank=%0d addr=%0d, want bank=%0d addr=%0d",
                 k, wr_q[k].bank, wr_q[k].addr, exp_w.bank, exp_w.addr);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #1;
    test_reset();
    test_full_rate();
    test_data_integrity();
    test_gappy();
    test_no_release();
    test_zero_and_busy_start();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
